mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipeline MEM stage that executes loads and stores against a word-wide data memory through a req/ack handshake. It sits between the EXE/MEM register and the MEM/WB register. It produces the write-back data, destination register and enable that the MEM/WB register captures. While a memory access is outstanding, it requests a pipeline stall from the hazard unit.

## Interface
- TIMEOUT_CYCLES, 255, number of BUSY cycles without MEM_ACK before a bus error is declared (used only with MEM_TIMEOUT_EN); minimum value 1.
- CLOCK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  one clock; reset is synchronous and active-high.
- ALUResult_IN  in  32  effective address for loads/stores; pass-through result otherwise.
- StoreData_IN  in  32  store source register value.
- MemRead_IN / MemWrite_IN  in  1 each  load / store request; both high is illegal and is treated as a load.
- MemSize_IN  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- MemSigned_IN  in  1  sign-extend loaded byte/half when 1, zero-extend when 0.
- WriteRegister_IN  in  5  destination register.
- WriteEnable_IN  in  1  register write enable.
- STALL_IN  in  1  hazard unit holds the EXE/MEM register (external stall).
- FLUSH_IN  in  1  kill the instruction currently in this stage.
- MEM_RDATA  in  32  memory read data, valid when MEM_ACK=1.
- MEM_ACK  in  1  memory completion, a one-cycle pulse.
- MEM_REQ  out  1  registered request; held until MEM_ACK.
- MEM_WE  out  1  registered write strobe; valid with MEM_REQ.
- MEM_ADDR  out  32  registered word address, {ALUResult_IN[31:2],2'b00}.
- MEM_WDATA  out  32  registered lane-replicated store data.
- MEM_BE  out  4  registered byte enables.
- WriteData_OUT  out  32  data to MEM/WB.
- WriteRegister_OUT  out  5  destination register to MEM/WB.
- WriteEnable_OUT  out  1  write enable to MEM/WB.
- STALL_REQ_OUT  out  1  stall request to the hazard unit.
- ALIGN_ERR_OUT  out  1  misaligned access detected (combinational).
- BUS_ERR_OUT  out  1  one-cycle pulse when an access times out.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. Reset puts it in IDLE.
- Reset clears every registered output to 0: MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE, BUS_ERR_OUT, the load capture register and the kill flag.
- The stage has an access when (MemRead_IN|MemWrite_IN) & !FLUSH_IN & aligned.
- Alignment rules:
  - A half access is misaligned when addr[0]=1.
  - A word access is misaligned when addr[1:0]≠0.
  - Byte accesses are always aligned.
  - On a misaligned access: ALIGN_ERR_OUT=1, no request is issued, WriteEnable_OUT=0, no stall is requested.
- IDLE with an access:
  - Load MEM_ADDR, MEM_WE=MemWrite_IN, MEM_BE and MEM_WDATA; set MEM_REQ=1; go to BUSY.
  - STALL_REQ_OUT=1 in this cycle.
- IDLE without an access: outputs pass through.
  - WriteData_OUT=ALUResult_IN.
  - WriteEnable_OUT=WriteEnable_IN&!FLUSH_IN.
- BUSY:
  - STALL_REQ_OUT=1.
  - On MEM_ACK: clear MEM_REQ and MEM_WE, capture the extracted load data, go to DONE.
- DONE:
  - STALL_REQ_OUT=0; WriteData_OUT comes from the capture register for loads and from ALUResult_IN for stores.
  - WriteEnable_OUT=WriteEnable_IN&!kill&!FLUSH_IN.
  - Return to IDLE when STALL_IN=0; otherwise stay in DONE. DONE never re-issues an access.
- Byte lanes are little-endian.
  - MEM_BE: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
  - MEM_WDATA: byte {4{data[7:0]}}; half {2{data[15:0]}}; word data.
  - Load extraction: shift MEM_RDATA right by 8*addr[1:0], then take [7:0] for byte or [15:0] for half, then sign- or zero-extend per MemSigned_IN.
- FLUSH_IN in BUSY sets the kill flag. The bus transaction still completes, so stores do write memory. The write-back is suppressed in DONE. The kill flag clears on DONE→IDLE.
- WriteRegister_OUT=WriteRegister_IN always.
- RESET during BUSY drops MEM_REQ on the next edge. The memory must tolerate the abandoned request.

## Timing
- Minimum latency for any load or store is 3 cycles in the stage: IDLE (issue), BUSY (at least 1 cycle), DONE (result).
- A BUSY cycle with MEM_ACK=1 transitions to DONE at the next edge.
- MEM_REQ rises on the edge leaving IDLE and falls on the edge after the MEM_ACK cycle.
- STALL_REQ_OUT is combinational from state and inputs. It is high in IDLE-with-access and in all BUSY cycles.
- A non-memory instruction takes 0 added cycles; the outputs are combinational pass-through.
- MEM_ACK seen while not in BUSY is ignored.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without MEM_ACK.
  - When it reaches TIMEOUT_CYCLES: drop MEM_REQ, pulse BUS_ERR_OUT for 1 cycle, set kill, go to DONE.
  - MEM_ACK in the same cycle as the timeout takes priority, so the access completes normally.
- MEM_TIMEOUT_EN undefined: BUSY waits indefinitely and BUS_ERR_OUT is tied to 0.

## Test plan
- Word load, address 0x100, ACK 2 cycles after REQ with MEM_RDATA=0xDEADBEEF → STALL_REQ_OUT high for 3 cycles; in DONE WriteData_OUT=0xDEADBEEF, WriteEnable_OUT=1.
- Signed byte load, address 0x103, MEM_RDATA=0x80FFFFFF → WriteData_OUT=0xFFFFFF80. Repeat unsigned → 0x00000080.
- Half store, address 0x102, StoreData_IN=0x0000ABCD → MEM_BE=4'b1100, MEM_WDATA=0xABCDABCD, MEM_WE=1, WriteEnable_OUT=0 when WriteEnable_IN=0.
- Word load at address 0x101 → ALIGN_ERR_OUT=1, MEM_REQ stays 0, STALL_REQ_OUT=0, WriteEnable_OUT=0.
- Load with FLUSH_IN pulsed in BUSY and STALL_IN held high for 2 cycles after ACK → one REQ only, state held in DONE for 2 cycles, WriteEnable_OUT=0 throughout.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ACK → MEM_REQ drops after 4 BUSY cycles, BUS_ERR_OUT pulses once, FSM passes DONE then IDLE.

Source files
------------

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues loads/stores over a req/ack memory port and
// produces write-back data. Define MEM_TIMEOUT_EN to enable the bus-error timeout.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] ALUResult_IN,
  input  logic [31:0] StoreData_IN,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  input  logic [1:0]  MemSize_IN,
  input  logic        MemSigned_IN,
  input  logic [4:0]  WriteRegister_IN,
  input  logic        WriteEnable_IN,
  input  logic        STALL_IN,
  input  logic        FLUSH_IN,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BE,
  output logic [31:0] WriteData_OUT,
  output logic [4:0]  WriteRegister_OUT,
  output logic        WriteEnable_OUT,
  output logic        STALL_REQ_OUT,
  output logic        ALIGN_ERR_OUT,
  output logic        BUS_ERR_OUT
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] load_data_q, load_data_d;
  logic        kill_q, kill_d;

  logic        is_byte, is_half, is_word;
  logic        is_mem, is_load, is_store;
  logic        misaligned, align_err, access;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;
  logic        stall_req;
  logic [31:0] write_data;
  logic        write_enable;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // Size 2'b11 decodes as word; both read and write high decodes as a load.
  always_comb begin
    is_byte    = (MemSize_IN == 2'b00);
    is_half    = (MemSize_IN == 2'b01);
    is_word    = MemSize_IN[1];
    is_mem     = MemRead_IN | MemWrite_IN;
    is_load    = MemRead_IN;
    is_store   = MemWrite_IN & ~MemRead_IN;
    misaligned = (is_half & ALUResult_IN[0]) | (is_word & (ALUResult_IN[1:0] != 2'b00));
    align_err  = is_mem & misaligned;
    access     = is_mem & ~FLUSH_IN & ~misaligned;
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = StoreData_IN;
    if (is_byte) begin
      be_next    = 4'b0001 << ALUResult_IN[1:0];
      wdata_next = {4{StoreData_IN[7:0]}};
    end else if (is_half) begin
      be_next    = 4'b0011 << ALUResult_IN[1:0];
      wdata_next = {2{StoreData_IN[15:0]}};
    end
  end

  always_comb begin
    rdata_shifted = MEM_RDATA >> {ALUResult_IN[1:0], 3'b000};
    load_ext      = rdata_shifted;
    if (is_byte) begin
      load_ext = {{24{MemSigned_IN & rdata_shifted[7]}}, rdata_shifted[7:0]};
    end else if (is_half) begin
      load_ext = {{16{MemSigned_IN & rdata_shifted[15]}}, rdata_shifted[15:0]};
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    load_data_d  = load_data_q;
    kill_d       = kill_q;
    stall_req    = 1'b0;
    write_data   = ALUResult_IN;
    write_enable = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
    bus_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (access) begin
          mem_req_d   = 1'b1;
          mem_we_d    = is_store;
          mem_addr_d  = {ALUResult_IN[31:2], 2'b00};
          mem_wdata_d = wdata_next;
          mem_be_d    = be_next;
          stall_req   = 1'b1;
          state_d     = BUSY;
`ifdef MEM_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end else begin
          write_enable = WriteEnable_IN & ~FLUSH_IN & ~align_err;
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        if (FLUSH_IN) begin
          kill_d = 1'b1;
        end
        // An ACK arriving in the timeout cycle still completes the access.
        if (MEM_ACK) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          load_data_d = load_ext;
          state_d     = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = 1'b1;
          kill_d    = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        write_data   = is_load ? load_data_q : ALUResult_IN;
        write_enable = WriteEnable_IN & ~kill_q & ~FLUSH_IN;
        if (!STALL_IN) begin
          kill_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      load_data_q <= '0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      load_data_q <= load_data_d;
      kill_q      <= kill_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign BUS_ERR_OUT = bus_err_q;
`else
  assign BUS_ERR_OUT = 1'b0;
`endif

  assign MEM_REQ           = mem_req_q;
  assign MEM_WE            = mem_we_q;
  assign MEM_ADDR          = mem_addr_q;
  assign MEM_WDATA         = mem_wdata_q;
  assign MEM_BE            = mem_be_q;
  assign WriteData_OUT     = write_data;
  assign WriteRegister_OUT = WriteRegister_IN;
  assign WriteEnable_OUT   = write_enable;
  assign STALL_REQ_OUT     = stall_req;
  assign ALIGN_ERR_OUT     = align_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage; inputs change on the falling edge
// and outputs are sampled 1ns later.
`timescale 1ns/1ps
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [4:0]  write_reg;
  logic        write_en;
  logic        stall_in;
  logic        flush_in;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] write_data_out;
  logic [4:0]  write_reg_out;
  logic        write_en_out;
  logic        stall_req_out;
  logic        align_err_out;
  logic        bus_err_out;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .CLOCK(clock),
    .RESET(reset),
    .ALUResult_IN(alu_result),
    .StoreData_IN(store_data),
    .MemRead_IN(mem_read),
    .MemWrite_IN(mem_write),
    .MemSize_IN(mem_size),
    .MemSigned_IN(mem_signed),
    .WriteRegister_IN(write_reg),
    .WriteEnable_IN(write_en),
    .STALL_IN(stall_in),
    .FLUSH_IN(flush_in),
    .MEM_RDATA(mem_rdata),
    .MEM_ACK(mem_ack),
    .MEM_REQ(mem_req),
    .MEM_WE(mem_we),
    .MEM_ADDR(mem_addr),
    .MEM_WDATA(mem_wdata),
    .MEM_BE(mem_be),
    .WriteData_OUT(write_data_out),
    .WriteRegister_OUT(write_reg_out),
    .WriteEnable_OUT(write_en_out),
    .STALL_REQ_OUT(stall_req_out),
    .ALIGN_ERR_OUT(align_err_out),
    .BUS_ERR_OUT(bus_err_out)
  );

  task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  task applyStimulus(input logic rd, input logic wr, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] sdata,
                     input logic [4:0] wreg, input logic wen);
    mem_read   = rd;
    mem_write  = wr;
    mem_size   = size;
    mem_signed = sgn;
    alu_result = addr;
    store_data = sdata;
    write_reg  = wreg;
    write_en   = wen;
  endtask

  task idleInputs();
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  // Issues an access on the next cycle, waits wait_cycles BUSY cycles, then
  // acknowledges with rdata; returns 1ns into the first DONE cycle.
  task runAccess(input logic rd, input logic wr, input logic [1:0] size, input logic sgn,
                 input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] wreg,
                 input logic wen, input int wait_cycles, input logic [31:0] rdata);
    @(negedge clock);
    applyStimulus(rd, wr, size, sgn, addr, sdata, wreg, wen);
    @(negedge clock);
    repeat (wait_cycles) @(negedge clock);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset     = 1'b1;
    stall_in  = 1'b0;
    flush_in  = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    idleInputs();
    repeat (2) @(negedge clock);
    #1;
    checkOutput("rst_req",   mem_req, 1'b0);
    checkOutput("rst_we",    mem_we, 1'b0);
    checkOutput("rst_addr",  mem_addr, 32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    checkOutput("rst_be",    mem_be, 4'h0);
    checkOutput("rst_buserr", bus_err_out, 1'b0);
    checkOutput("rst_stall", stall_req_out, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Non-memory pass-through, then flushed pass-through
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h12345678, 32'h0, 5'd7, 1'b1);
    #1;
    checkOutput("pt_data",  write_data_out, 32'h12345678);
    checkOutput("pt_we",    write_en_out, 1'b1);
    checkOutput("pt_wreg",  write_reg_out, 5'd7);
    checkOutput("pt_stall", stall_req_out, 1'b0);
    checkOutput("pt_align", align_err_out, 1'b0);
    flush_in = 1'b1;
    #1;
    checkOutput("pt_flush_we", write_en_out, 1'b0);
    flush_in = 1'b0;
    mem_ack  = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    #1;
    checkOutput("idle_ack_req",   mem_req, 1'b0);
    checkOutput("idle_ack_stall", stall_req_out, 1'b0);

    // Word load at 0x100, ACK in the second BUSY cycle
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd3, 1'b1);
    #1;
    checkOutput("wl_stall_idle", stall_req_out, 1'b1);
    checkOutput("wl_req_idle",   mem_req, 1'b0);
    @(negedge clock);
    #1;
    checkOutput("wl_req_busy", mem_req, 1'b1);
    checkOutput("wl_addr",     mem_addr, 32'h100);
    checkOutput("wl_be",       mem_be, 4'hF);
    checkOutput("wl_memwe",    mem_we, 1'b0);
    checkOutput("wl_stall_b1", stall_req_out, 1'b1);
    @(negedge clock);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("wl_stall_b2", stall_req_out, 1'b1);
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #1;
    checkOutput("wl_stall_done", stall_req_out, 1'b0);
    checkOutput("wl_data",  write_data_out, 32'hDEADBEEF);
    checkOutput("wl_we",    write_en_out, 1'b1);
    checkOutput("wl_req_done", mem_req, 1'b0);
    checkOutput("wl_wreg",  write_reg_out, 5'd3);

    // Byte and half loads with sign/zero extension
    runAccess(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd4, 1'b1, 0, 32'h80FFFFFF);
    checkOutput("lb_data", write_data_out, 32'hFFFFFF80);
    checkOutput("lb_we",   write_en_out, 1'b1);
    checkOutput("lb_align", align_err_out, 1'b0);
    runAccess(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd4, 1'b1, 0, 32'h80FFFFFF);
    checkOutput("lbu_data", write_data_out, 32'h00000080);
    runAccess(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 5'd5, 1'b1, 1, 32'hBEEF1234);
    checkOutput("lh_data", write_data_out, 32'hFFFFBEEF);

    // Half store at 0x102 with write-back disabled
    @(negedge clock);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 5'd9, 1'b0);
    #1;
    checkOutput("sh_stall_idle", stall_req_out, 1'b1);
    @(negedge clock);
    #1;
    checkOutput("sh_req",   mem_req, 1'b1);
    checkOutput("sh_be",    mem_be, 4'b1100);
    checkOutput("sh_wdata", mem_wdata, 32'hABCDABCD);
    checkOutput("sh_memwe", mem_we, 1'b1);
    checkOutput("sh_addr",  mem_addr, 32'h100);
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    #1;
    checkOutput("sh_memwe_done", mem_we, 1'b0);
    checkOutput("sh_req_done",   mem_req, 1'b0);
    checkOutput("sh_we",         write_en_out, 1'b0);
    checkOutput("sh_data",       write_data_out, 32'h102);

    // Misaligned accesses are rejected without a request
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd2, 1'b1);
    #1;
    checkOutput("mis_w_align", align_err_out, 1'b1);
    checkOutput("mis_w_stall", stall_req_out, 1'b0);
    checkOutput("mis_w_we",    write_en_out, 1'b0);
    @(negedge clock);
    #1;
    checkOutput("mis_w_req", mem_req, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 5'd2, 1'b1);
    #1;
    checkOutput("mis_h_align", align_err_out, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd2, 1'b1);
    flush_in = 1'b1;
    #1;
    checkOutput("al_h_align", align_err_out, 1'b0);
    checkOutput("al_h_flush_stall", stall_req_out, 1'b0);
    flush_in = 1'b0;
    idleInputs();

    // Flush during BUSY, DONE held by external stall
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 5'd6, 1'b1);
    @(negedge clock);
    flush_in = 1'b1;
    #1;
    checkOutput("fl_stall_busy", stall_req_out, 1'b1);
    @(negedge clock);
    flush_in  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h11223344;
    stall_in  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      if (i == 3) stall_in = 1'b0;
      #1;
      checkOutput($sformatf("fl_we_d%0d", i),    write_en_out, 1'b0);
      checkOutput($sformatf("fl_req_d%0d", i),   mem_req, 1'b0);
      checkOutput($sformatf("fl_stall_d%0d", i), stall_req_out, 1'b0);
      checkOutput($sformatf("fl_data_d%0d", i),  write_data_out, 32'h11223344);
    end
    runAccess(1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 5'd1, 1'b1, 0, 32'h000000A5);
    checkOutput("kill_clr_data", write_data_out, 32'h000000A5);
    checkOutput("kill_clr_we",   write_en_out, 1'b1);

`ifdef MEM_TIMEOUT_EN
    // No ACK: times out after 4 BUSY cycles
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd8, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      #1;
      checkOutput($sformatf("to_req_b%0d", i),    mem_req, 1'b1);
      checkOutput($sformatf("to_buserr_b%0d", i), bus_err_out, 1'b0);
    end
    @(negedge clock);
    #1;
    checkOutput("to_req_done",    mem_req, 1'b0);
    checkOutput("to_buserr_done", bus_err_out, 1'b1);
    checkOutput("to_we_done",     write_en_out, 1'b0);
    checkOutput("to_stall_done",  stall_req_out, 1'b0);
    @(negedge clock);
    #1;
    checkOutput("to_buserr_idle", bus_err_out, 1'b0);
    checkOutput("to_stall_idle",  stall_req_out, 1'b1);
    idleInputs();
    @(negedge clock);
    #1;
    checkOutput("to_req_after", mem_req, 1'b0);
`else
    // Without the timeout, BUSY waits for a late ACK
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd8, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      #1;
      checkOutput($sformatf("wait_req_b%0d", i),    mem_req, 1'b1);
      checkOutput($sformatf("wait_buserr_b%0d", i), bus_err_out, 1'b0);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #1;
    checkOutput("wait_data", write_data_out, 32'hCAFEF00D);
    checkOutput("wait_we",   write_en_out, 1'b1);
    checkOutput("wait_req",  mem_req, 1'b0);
`endif

    @(negedge clock);
    idleInputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
